merge_seq_ctrl: RTL and testbench

- Sequencer for the dual index/data memory datapath (two 16-entry index RAMs holding sorted 8-bit keys, two 16-entry data RAMs).
- After load, on `start` it walks both index RAMs and emits one merged, ascending stream of (list select, entry address, key).
- Downstream logic uses that stream to read the matching data RAM entry.
- It also owns the shared write enable: external writes are gated off while a merge runs.

---
 rtl/merge_seq_pkg.sv | 18 +
 rtl/merge_seq_ctrl_pick.sv | 22 ++
 rtl/merge_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_merge_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_seq_pkg.sv
// Shared definitions for the two-list merge sequencer: state encoding,
// default widths and list-select constants.
package merge_seq_pkg;

    localparam int DEF_KEY_W = 8;
    localparam int DEF_AW    = 4;

    localparam logic LIST1 = 1'b0;
    localparam logic LIST2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/merge_seq_ctrl_pick.sv
// Selection rule for one merge step: smaller head key wins, ties go to
// list 1 (stable merge), an exhausted list is never chosen.
module merge_pick
    import merge_seq_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W
) (
    input  logic [KEY_W-1:0] r1,
    input  logic [KEY_W-1:0] r2,
    input  logic             e1,
    input  logic             e2,
    output logic             sel
);

    always_comb begin
        sel = LIST2;
        if (!e1 && (e2 || (r1 <= r2))) begin
            sel = LIST1;
        end
    end

endmodule

// File: rtl/merge_seq_ctrl.sv
// Walks two sorted index RAMs and emits one ascending (list, addr, key)
// stream at two cycles per element; gates host writes while merging.
module merge_seq_ctrl
    import merge_seq_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW:0]      len1,
    input  logic [AW:0]      len2,
    input  logic [KEY_W-1:0] r1,
    input  logic [KEY_W-1:0] r2,
    output logic [AW-1:0]    cnt1,
    output logic [AW-1:0]    cnt2,
    input  logic             ext_wr_en,
    output logic             mem_wr_en,
    output logic             wr_blocked,
    output logic             out_valid,
    output logic             out_sel,
    output logic [AW-1:0]    out_addr,
    output logic [KEY_W-1:0] out_key,
    output logic             busy,
    output logic             done
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    state_t      state;
    state_t      state_nx;
    logic [AW:0] p1, p2;
    logic [AW:0] l1, l2;
    logic [AW:0] l1_in, l2_in;
    logic        e1, e2;
    logic        sel;
    logic        last;

    assign l1_in     = (len1 > DEPTH) ? DEPTH : len1;
    assign l2_in     = (len2 > DEPTH) ? DEPTH : len2;
    assign cnt1      = p1[AW-1:0];
    assign cnt2      = p2[AW-1:0];
    assign mem_wr_en = ext_wr_en & ~busy;
    assign e1        = (p1 == l1);
    assign e2        = (p2 == l2);

    merge_pick #(.KEY_W(KEY_W)) u_pick (
        .r1  (r1),
        .r2  (r2),
        .e1  (e1),
        .e2  (e2),
        .sel (sel)
    );

    // True when the element taken this cycle is the final one of the merge.
    assign last = (sel == LIST1) ? (((p1 + ONE) == l1) && e2)
                                 : (((p2 + ONE) == l2) && e1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ((l1_in == '0) && (l2_in == '0)) ? DONE : FETCH;
                end
            end
            FETCH:   state_nx = CMP;
            CMP:     state_nx = last ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            p1         <= '0;
            p2         <= '0;
            l1         <= '0;
            l2         <= '0;
            out_valid  <= 1'b0;
            out_sel    <= 1'b0;
            out_addr   <= '0;
            out_key    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_blocked <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            done       <= 1'b0;
            wr_blocked <= ext_wr_en & busy;
            case (state)
                IDLE: begin
                    if (start) begin
                        p1   <= '0;
                        p2   <= '0;
                        l1   <= l1_in;
                        l2   <= l2_in;
                        busy <= (state_nx == FETCH);
                    end
                end
                CMP: begin
                    out_valid <= 1'b1;
                    out_sel   <= sel;
                    if (sel == LIST1) begin
                        out_addr <= p1[AW-1:0];
                        out_key  <= r1;
                        p1       <= p1 + ONE;
                    end else begin
                        out_addr <= p2[AW-1:0];
                        out_key  <= r2;
                        p2       <= p2 + ONE;
                    end
                    if (last) begin
                        busy <= 1'b0;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_merge_seq_ctrl.sv
// Directed bench for merge_seq_ctrl with behavioural index RAMs (one-cycle
// read latency) and hand-computed expected merge streams.
module tb_merge_seq_ctrl;
    import merge_seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] len1, len2;
    logic [7:0] r1, r2;
    logic [3:0] cnt1, cnt2;
    logic       ext_wr_en;
    logic       mem_wr_en;
    logic       wr_blocked;
    logic       out_valid;
    logic       out_sel;
    logic [3:0] out_addr;
    logic [7:0] out_key;
    logic       busy;
    logic       done;

    logic [7:0] mem1 [16];
    logic [7:0] mem2 [16];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int         n_cap;
    logic [7:0] cap_key  [40];
    logic       cap_sel  [40];
    logic [3:0] cap_addr [40];
    int         cap_k    [40];
    int         done_k;
    logic       busy_k0, busy_seen, busy_at_done;
    int         wb_cnt;

    logic [7:0] exp_key  [40];
    logic       exp_sel  [40];
    logic [3:0] exp_addr [40];

    merge_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len1       (len1),
        .len2       (len2),
        .r1         (r1),
        .r2         (r2),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .ext_wr_en  (ext_wr_en),
        .mem_wr_en  (mem_wr_en),
        .wr_blocked (wr_blocked),
        .out_valid  (out_valid),
        .out_sel    (out_sel),
        .out_addr   (out_addr),
        .out_key    (out_key),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        r1 <= mem1[cnt1];
        r2 <= mem2[cnt2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_merge(input logic [4:0] l1, input logic [4:0] l2);
        @(negedge clk);
        len1  = l1;
        len2  = l2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // k counts negedges after the accepted start edge (k = 0 is the first).
    task automatic capture(input int wr_k, input int st_k, input int budget);
        int k;
        n_cap = 0; done_k = -1; wb_cnt = 0;
        busy_k0 = 1'b0; busy_seen = 1'b0; busy_at_done = 1'b1;
        k = 0;
        while (done_k < 0 && k < budget) begin
            @(negedge clk);
            if (k == 0) busy_k0 = busy;
            if (busy) busy_seen = 1'b1;
            if (wr_blocked) wb_cnt++;
            if (out_valid && n_cap < 40) begin
                cap_key[n_cap]  = out_key;
                cap_sel[n_cap]  = out_sel;
                cap_addr[n_cap] = out_addr;
                cap_k[n_cap]    = k;
                n_cap++;
            end
            if (done) begin
                done_k       = k;
                busy_at_done = busy;
            end
            if (k == wr_k) begin
                ext_wr_en = 1'b1;
                #1 check("mem_wr_en_gated", 32'(mem_wr_en), 32'd0);
            end
            if (k == wr_k + 1) ext_wr_en = 1'b0;
            if (k == st_k) begin
                start = 1'b1;
                len1  = 5'd0;
                len2  = 5'd1;
            end
            if (k == st_k + 1) start = 1'b0;
            k++;
        end
        check("done_within_budget", 32'(done_k >= 0), 32'd1);
    endtask

    task automatic verify(input string name, input int n_exp);
        check({name, " count"}, 32'(n_cap), 32'(n_exp));
        for (int j = 0; j < n_exp && j < n_cap; j++) begin
            check($sformatf("%s key%0d", name, j),  32'(cap_key[j]),  32'(exp_key[j]));
            check($sformatf("%s sel%0d", name, j),  32'(cap_sel[j]),  32'(exp_sel[j]));
            check($sformatf("%s addr%0d", name, j), 32'(cap_addr[j]), 32'(exp_addr[j]));
            check($sformatf("%s time%0d", name, j), 32'(cap_k[j]),    32'(2 + 2 * j));
        end
        check({name, " done_time"}, 32'(done_k), 32'(2 * n_exp + 1));
        if (n_exp == 0) check({name, " busy_never"}, 32'(busy_seen), 32'd0);
        else            check({name, " busy_after_start"}, 32'(busy_k0), 32'd1);
        check({name, " busy_at_done"}, 32'(busy_at_done), 32'd0);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 8'hff;
            mem2[i] = 8'hff;
        end
        mem1[0] = 8'd3; mem1[1] = 8'd7; mem1[2] = 8'd9;
        mem2[0] = 8'd1; mem2[1] = 8'd8;
        exp_key[0] = 8'd1; exp_sel[0] = 1'b1; exp_addr[0] = 4'd0;
        exp_key[1] = 8'd3; exp_sel[1] = 1'b0; exp_addr[1] = 4'd0;
        exp_key[2] = 8'd7; exp_sel[2] = 1'b0; exp_addr[2] = 4'd1;
        exp_key[3] = 8'd8; exp_sel[3] = 1'b1; exp_addr[3] = 4'd1;
        exp_key[4] = 8'd9; exp_sel[4] = 1'b0; exp_addr[4] = 4'd2;
    endtask

    initial begin
        int k, nv, dn;
        reset = 1'b0; start = 1'b0; ext_wr_en = 1'b0;
        len1 = '0; len2 = '0;
        for (int i = 0; i < 16; i++) begin
            mem1[i] = '0;
            mem2[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_sel", 32'(out_sel), 32'd0);
        check("rst out_addr", 32'(out_addr), 32'd0);
        check("rst out_key", 32'(out_key), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst wr_blocked", 32'(wr_blocked), 32'd0);
        check("rst cnt1", 32'(cnt1), 32'd0);
        check("rst cnt2", 32'(cnt2), 32'd0);
        check("rst state", 32'(dut.state), 32'(IDLE));
        reset = 1'b1;

        // Write enable passes straight through while idle.
        @(negedge clk);
        ext_wr_en = 1'b1;
        #1 check("idle mem_wr_en on", 32'(mem_wr_en), 32'd1);
        ext_wr_en = 1'b0;
        #1 check("idle mem_wr_en off", 32'(mem_wr_en), 32'd0);

        // Normal merge with a host write attempted mid-merge.
        load_basic();
        start_merge(5'd3, 5'd2);
        capture(3, -1, 60);
        verify("basic", 5);
        check("wr_blocked pulses", 32'(wb_cnt), 32'd1);

        // Ties resolve to list 1 first.
        mem1[0] = 8'd5; mem1[1] = 8'd5; mem2[0] = 8'd5;
        exp_key[0] = 8'd5; exp_sel[0] = 1'b0; exp_addr[0] = 4'd0;
        exp_key[1] = 8'd5; exp_sel[1] = 1'b0; exp_addr[1] = 4'd1;
        exp_key[2] = 8'd5; exp_sel[2] = 1'b1; exp_addr[2] = 4'd0;
        start_merge(5'd2, 5'd1);
        capture(-1, -1, 60);
        verify("ties", 3);

        // Both lists empty.
        start_merge(5'd0, 5'd0);
        capture(-1, -1, 20);
        verify("empty", 0);

        // Only list 2 populated.
        mem2[0] = 8'd10; mem2[1] = 8'd20; mem2[2] = 8'd30; mem2[3] = 8'd40;
        for (int j = 0; j < 4; j++) begin
            exp_key[j]  = 8'(10 * (j + 1));
            exp_sel[j]  = 1'b1;
            exp_addr[j] = 4'(j);
        end
        start_merge(5'd0, 5'd4);
        capture(-1, -1, 40);
        verify("one_sided", 4);

        // Full depth, interleaved keys, len1 = 20 clamps to 16.
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 8'(2 * i);
            mem2[i] = 8'(2 * i + 1);
        end
        for (int j = 0; j < 32; j++) begin
            exp_key[j]  = 8'(j);
            exp_sel[j]  = 1'(j % 2);
            exp_addr[j] = 4'(j / 2);
        end
        start_merge(5'd20, 5'd16);
        capture(-1, -1, 200);
        verify("full", 32);

        // Reset after the second element aborts the merge silently.
        load_basic();
        start_merge(5'd3, 5'd2);
        k = 0; nv = 0;
        while (nv < 2 && k < 40) begin
            @(negedge clk);
            if (out_valid) nv++;
            k++;
        end
        check("abort reached 2nd element", 32'(nv), 32'd2);
        reset = 1'b0;
        @(negedge clk);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort out_sel", 32'(out_sel), 32'd0);
        check("abort out_addr", 32'(out_addr), 32'd0);
        check("abort out_key", 32'(out_key), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort cnt1", 32'(cnt1), 32'd0);
        check("abort cnt2", 32'(cnt2), 32'd0);
        check("abort state", 32'(dut.state), 32'(IDLE));
        reset = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort no done", 32'(dn), 32'd0);

        // Restart reruns from address 0; a second start while busy is ignored.
        start_merge(5'd3, 5'd2);
        capture(-1, 3, 60);
        verify("restart", 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
